// File: rtl/alu_share_arb_if.sv
// Bundle of request/response handshakes and ALU-side signals for alu_share_arb.
// slave = arbiter side; master = clients plus the ALU instance.
interface alu_share_arb_if #(
    parameter int W = 32
);
    logic [1:0]     req_valid;
    logic [1:0]     req_ready;
    logic [2*W-1:0] req_a;
    logic [2*W-1:0] req_b;
    logic [5:0]     req_op;
    logic [1:0]     rsp_valid;
    logic [1:0]     rsp_ready;
    logic [W-1:0]   rsp_z;
    logic           rsp_ex;
    logic           rsp_err;
    logic [W-1:0]   alu_a;
    logic [W-1:0]   alu_b;
    logic [2:0]     alu_op;
    logic [W-1:0]   alu_z;
    logic           alu_ex;

    modport slave (
        input  req_valid, req_a, req_b, req_op, rsp_ready, alu_z, alu_ex,
        output req_ready, rsp_valid, rsp_z, rsp_ex, rsp_err, alu_a, alu_b, alu_op
    );

    modport master (
        output req_valid, req_a, req_b, req_op, rsp_ready, alu_z, alu_ex,
        input  req_ready, rsp_valid, rsp_z, rsp_ex, rsp_err, alu_a, alu_b, alu_op
    );
endinterface

// File: rtl/alu_share_arb.sv
// Two-port round-robin arbiter sharing one ALU: IDLE -> EXEC -> RESP per operation.
// Optional macro ALU_SHARE_FIXED_PRIO_EN: port 0 always wins contention (no rr pointer).
module alu_share_arb #(
    parameter int W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_share_arb_if.slave    bus
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t         state_reg;
    logic [W-1:0]   a_reg;
    logic [W-1:0]   b_reg;
    logic [2:0]     op_reg;
    logic           gnt_q;
    logic [1:0]     rsp_valid_reg;
    logic [W-1:0]   rsp_z_reg;
    logic           rsp_ex_reg;
    logic           rsp_err_reg;

    logic           win;
    logic           any_valid;
    logic [W-1:0]   win_a;
    logic [W-1:0]   win_b;
    logic [2:0]     win_op;

    function automatic logic op_legal(input logic [2:0] op);
        case (op)
            3'b000, 3'b001, 3'b010, 3'b110, 3'b111: op_legal = 1'b1;
            default:                                op_legal = 1'b0;
        endcase
    endfunction

    assign any_valid = |bus.req_valid;

`ifdef ALU_SHARE_FIXED_PRIO_EN
    assign win = ~bus.req_valid[0];
`else
    logic rr_q;
    // Contention goes to the preferred port; a lone requester always wins.
    assign win = (&bus.req_valid) ? rr_q : bus.req_valid[1];
`endif

    assign win_a  = win ? bus.req_a[W +: W]  : bus.req_a[0 +: W];
    assign win_b  = win ? bus.req_b[W +: W]  : bus.req_b[0 +: W];
    assign win_op = win ? bus.req_op[3 +: 3] : bus.req_op[0 +: 3];

    // rst_n gating keeps req_ready low for the whole time reset is held.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ready
            assign bus.req_ready[gi] = rst_n && (state_reg == IDLE) &&
                                       bus.req_valid[gi] && (win == 1'(gi));
        end
    endgenerate

    assign bus.alu_a     = a_reg;
    assign bus.alu_b     = b_reg;
    assign bus.alu_op    = op_reg;
    assign bus.rsp_valid = rsp_valid_reg;
    assign bus.rsp_z     = rsp_z_reg;
    assign bus.rsp_ex    = rsp_ex_reg;
    assign bus.rsp_err   = rsp_err_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            a_reg         <= '0;
            b_reg         <= '0;
            op_reg        <= 3'b000;
            gnt_q         <= 1'b0;
            rsp_valid_reg <= 2'b00;
            rsp_z_reg     <= '0;
            rsp_ex_reg    <= 1'b0;
            rsp_err_reg   <= 1'b0;
`ifndef ALU_SHARE_FIXED_PRIO_EN
            rr_q          <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (any_valid) begin
                        a_reg  <= win_a;
                        b_reg  <= win_b;
                        op_reg <= win_op;
                        gnt_q  <= win;
`ifndef ALU_SHARE_FIXED_PRIO_EN
                        rr_q   <= ~win;
`endif
                        if (op_legal(win_op)) begin
                            state_reg <= EXEC;
                        end else begin
                            // Illegal op skips the ALU and answers immediately.
                            state_reg     <= RESP;
                            rsp_z_reg     <= '0;
                            rsp_ex_reg    <= 1'b0;
                            rsp_err_reg   <= 1'b1;
                            rsp_valid_reg <= {win, ~win};
                        end
                    end
                end
                EXEC: begin
                    rsp_z_reg     <= bus.alu_z;
                    rsp_ex_reg    <= bus.alu_ex;
                    rsp_err_reg   <= 1'b0;
                    rsp_valid_reg <= {gnt_q, ~gnt_q};
                    state_reg     <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready[gnt_q]) begin
                        rsp_valid_reg <= 2'b00;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule
